// File: rtl/store_buffer_ooo_if.sv
// Bundle between the MEM stage / ROB / data memory and the store buffer.
// The master side drives requests; the slave side is the buffer.
interface store_buffer_ooo_if #(
   parameter int unsigned SB_DEPTH = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32
);
   localparam int unsigned IDX_W = $clog2(SB_DEPTH);
   localparam int unsigned BE_W  = DATA_W / 8;

   logic              alloc_valid_i;
   logic              alloc_ready_o;
   logic [ADDR_W-1:0] alloc_addr_i;
   logic [DATA_W-1:0] alloc_data_i;
   logic [BE_W-1:0]   alloc_be_i;
   logic [IDX_W-1:0]  alloc_idx_o;
   logic              commit_valid_i;
   logic [IDX_W-1:0]  commit_idx_i;
   logic              flush_i;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic [DATA_W-1:0] mem_req_data_o;
   logic [BE_W-1:0]   mem_req_be_o;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [BE_W-1:0]   ld_be_i;
   logic              ld_hit_o;
   logic [DATA_W-1:0] ld_data_o;
   logic              ld_stall_o;
   logic [IDX_W:0]    count_o;
   logic              empty_o;
   logic              full_o;

   modport master (
      output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_be_i,
      output commit_valid_i, commit_idx_i, flush_i, mem_req_ready_i, ld_addr_i, ld_be_i,
      input  alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o,
      input  mem_req_be_o, ld_hit_o, ld_data_o, ld_stall_o, count_o, empty_o, full_o
   );

   modport slave (
      input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_be_i,
      input  commit_valid_i, commit_idx_i, flush_i, mem_req_ready_i, ld_addr_i, ld_be_i,
      output alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o,
      output mem_req_be_o, ld_hit_o, ld_data_o, ld_stall_o, count_o, empty_o, full_o
   );
endinterface

// File: rtl/store_buffer_ooo.sv
// In-order store buffer with head/commit/tail pointers, memory drain and load forwarding.
// Define SB_FORWARD_EN for full store-to-load forwarding; otherwise overlapping loads stall.
module store_buffer_ooo #(
   parameter int unsigned SB_DEPTH = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32
) (
   input logic               clk_i,
   input logic               rstn_i,
   store_buffer_ooo_if.slave sb_io
);
   localparam int unsigned IDX_W = $clog2(SB_DEPTH);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

   logic [PTR_W-1:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
   logic [PTR_W-1:0]  count;
   logic [IDX_W-1:0]  head_idx, tail_idx;
   logic [ADDR_W-1:0] addr_q [SB_DEPTH];
   logic [DATA_W-1:0] data_q [SB_DEPTH];
   logic [BE_W-1:0]   be_q   [SB_DEPTH];
   logic              full, empty;
   logic              alloc_fire, commit_legal, commit_fire, drain_valid, drain_fire;

   assign head_idx = head_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];
   assign count    = tail_q - head_q;
   assign full     = (count == PTR_W'(SB_DEPTH));
   assign empty    = (count == '0);

   assign alloc_fire   = sb_io.alloc_valid_i && !full && !sb_io.flush_i;
   assign commit_legal = (sb_io.commit_idx_i == cmt_q[IDX_W-1:0]) && (cmt_q != tail_q);
   assign commit_fire  = sb_io.commit_valid_i && commit_legal;
   assign drain_valid  = (head_q != cmt_q);
   assign drain_fire   = drain_valid && sb_io.mem_req_ready_i;

   // Flush rewinds tail to the post-commit pointer so a same-cycle commit survives.
   always_comb begin
      head_d = head_q + {{IDX_W{1'b0}}, drain_fire};
      cmt_d  = cmt_q + {{IDX_W{1'b0}}, commit_fire};
      tail_d = tail_q + {{IDX_W{1'b0}}, alloc_fire};
      if (sb_io.flush_i) begin
         tail_d = cmt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         cmt_q  <= cmt_d;
         tail_q <= tail_d;
      end
   end

   // Entry storage needs no reset: validity comes from the pointer window.
   always_ff @(posedge clk_i) begin
      if (alloc_fire) begin
         addr_q[tail_idx] <= sb_io.alloc_addr_i & WORD_MASK;
         data_q[tail_idx] <= sb_io.alloc_data_i;
         be_q[tail_idx]   <= sb_io.alloc_be_i;
      end
   end

   assign sb_io.alloc_ready_o   = !full && !sb_io.flush_i;
   assign sb_io.alloc_idx_o     = tail_idx;
   assign sb_io.mem_req_valid_o = drain_valid;
   assign sb_io.mem_req_addr_o  = addr_q[head_idx];
   assign sb_io.mem_req_data_o  = data_q[head_idx];
   assign sb_io.mem_req_be_o    = be_q[head_idx];
   assign sb_io.count_o         = count;
   assign sb_io.empty_o         = empty;
   assign sb_io.full_o          = full;

   logic             any_match;
   logic [IDX_W-1:0] scan_idx;
`ifdef SB_FORWARD_EN
   logic              yng_match, yng_cover;
   logic [DATA_W-1:0] yng_data;
`endif

   // Scan oldest to youngest so the last match seen is the youngest.
   always_comb begin
      any_match = 1'b0;
      scan_idx  = '0;
`ifdef SB_FORWARD_EN
      yng_match = 1'b0;
      yng_cover = 1'b0;
      yng_data  = '0;
`endif
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
         scan_idx = head_idx + IDX_W'(k);
         if ((PTR_W'(k) < count) &&
             (addr_q[scan_idx] == (sb_io.ld_addr_i & WORD_MASK)) &&
             ((sb_io.ld_be_i & be_q[scan_idx]) != '0)) begin
            any_match = 1'b1;
`ifdef SB_FORWARD_EN
            yng_match = 1'b1;
            yng_cover = ((sb_io.ld_be_i & ~be_q[scan_idx]) == '0);
            yng_data  = data_q[scan_idx];
`endif
         end
      end
   end

`ifdef SB_FORWARD_EN
   assign sb_io.ld_hit_o   = yng_match && yng_cover;
   assign sb_io.ld_data_o  = (yng_match && yng_cover) ? yng_data : '0;
   assign sb_io.ld_stall_o = any_match && !(yng_match && yng_cover);
`else
   assign sb_io.ld_hit_o   = 1'b0;
   assign sb_io.ld_data_o  = '0;
   assign sb_io.ld_stall_o = any_match;
`endif

   commit_in_order_a : assert property (
      @(posedge clk_i) disable iff (!rstn_i) sb_io.commit_valid_i |-> commit_legal
   ) else $error("store_buffer_ooo: out-of-order or empty commit");
endmodule

// File: tb/tb_store_buffer_ooo.sv
// Directed bench for store_buffer_ooo: vector table for fill/full/flush plus hand-written
// sequences for drain back-pressure, reset mid-drain, commit+flush, forwarding and wrap.
module tb_store_buffer_ooo;
   localparam int unsigned SB_DEPTH = 4;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
`ifdef SB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   store_buffer_ooo_if #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb ();

   store_buffer_ooo #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .sb_io  (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [31:0] addr;
      logic [31:0] data;
      logic        flush;
      logic        exp_ready;
      logic [1:0]  exp_idx;
      logic [2:0]  exp_count;
      logic        exp_full;
      logic        exp_empty;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sb.alloc_valid_i   = 1'b0;
      sb.alloc_addr_i    = '0;
      sb.alloc_data_i    = '0;
      sb.alloc_be_i      = '0;
      sb.commit_valid_i  = 1'b0;
      sb.commit_idx_i    = '0;
      sb.flush_i         = 1'b0;
      sb.mem_req_ready_i = 1'b0;
      sb.ld_addr_i       = '0;
      sb.ld_be_i         = '0;
   endtask

   task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      sb.alloc_valid_i = 1'b1;
      sb.alloc_addr_i  = a;
      sb.alloc_data_i  = d;
      sb.alloc_be_i    = be;
   endtask

   task automatic probe(input string name, input logic [31:0] a, input logic [3:0] be,
                        input logic hit, input logic [31:0] data, input logic stall);
      sb.ld_addr_i = a;
      sb.ld_be_i   = be;
      #1;
      chk({name, "_hit"}, 64'(sb.ld_hit_o), 64'(hit));
      chk({name, "_data"}, 64'(sb.ld_data_o), 64'(data));
      chk({name, "_stall"}, 64'(sb.ld_stall_o), 64'(stall));
   endtask

   initial begin
      int drained;
      checks   = 0;
      failures = 0;
      idle();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;

      // Reset state
      chk("rst_ready", 64'(sb.alloc_ready_o), 64'd1);
      chk("rst_memv", 64'(sb.mem_req_valid_o), 64'd0);
      chk("rst_count", 64'(sb.count_o), 64'd0);
      chk("rst_empty", 64'(sb.empty_o), 64'd1);
      chk("rst_full", 64'(sb.full_o), 64'd0);
      probe("rst_ld", 32'h40, 4'hF, 1'b0, 32'h0, 1'b0);
      tick();

      // Fill to full, ignored fifth alloc, flush with nothing committed
      tbl[0] = '{1'b1, 32'h40, 32'h1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 32'h44, 32'h2, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 32'h48, 32'h3, 1'b0, 1'b1, 2'd2, 3'd2, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 32'h4C, 32'h4, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 32'h50, 32'h5, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 32'h54, 32'h6, 1'b1, 1'b0, 2'd0, 3'd4, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 32'h00, 32'h0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         idle();
         sb.alloc_valid_i = tbl[i].av;
         sb.alloc_addr_i  = tbl[i].addr;
         sb.alloc_data_i  = tbl[i].data;
         sb.alloc_be_i    = 4'hF;
         sb.flush_i       = tbl[i].flush;
         #1;
         chk($sformatf("v%0d_ready", i), 64'(sb.alloc_ready_o), 64'(tbl[i].exp_ready));
         chk($sformatf("v%0d_idx", i), 64'(sb.alloc_idx_o), 64'(tbl[i].exp_idx));
         chk($sformatf("v%0d_count", i), 64'(sb.count_o), 64'(tbl[i].exp_count));
         chk($sformatf("v%0d_full", i), 64'(sb.full_o), 64'(tbl[i].exp_full));
         chk($sformatf("v%0d_empty", i), 64'(sb.empty_o), 64'(tbl[i].exp_empty));
         chk($sformatf("v%0d_memv", i), 64'(sb.mem_req_valid_o), 64'd0);
         tick();
      end
      idle();

      // Drain with memory back-pressure
      alloc(32'h100, 32'hDEADBEEF, 4'hF);
      #1;
      chk("bp_idx", 64'(sb.alloc_idx_o), 64'd0);
      tick();
      idle();
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = 2'd0;
      #1;
      chk("bp_memv_commit_cycle", 64'(sb.mem_req_valid_o), 64'd0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_memv", i), 64'(sb.mem_req_valid_o), 64'd1);
         chk($sformatf("bp%0d_addr", i), 64'(sb.mem_req_addr_o), 64'h100);
         chk($sformatf("bp%0d_data", i), 64'(sb.mem_req_data_o), 64'hDEADBEEF);
         chk($sformatf("bp%0d_be", i), 64'(sb.mem_req_be_o), 64'hF);
         chk($sformatf("bp%0d_count", i), 64'(sb.count_o), 64'd1);
         tick();
      end
      sb.mem_req_ready_i = 1'b1;
      #1;
      chk("bp_memv_ready", 64'(sb.mem_req_valid_o), 64'd1);
      tick();
      idle();
      #1;
      chk("bp_empty_after", 64'(sb.empty_o), 64'd1);
      chk("bp_memv_after", 64'(sb.mem_req_valid_o), 64'd0);
      tick();

      // Asynchronous reset while a committed store waits to drain
      alloc(32'h80, 32'h55, 4'hF);
      #1;
      chk("rd_idx", 64'(sb.alloc_idx_o), 64'd1);
      tick();
      idle();
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = 2'd1;
      tick();
      idle();
      #1;
      chk("rd_memv_before", 64'(sb.mem_req_valid_o), 64'd1);
      rstn = 1'b0;
      #1;
      chk("rd_memv", 64'(sb.mem_req_valid_o), 64'd0);
      chk("rd_count", 64'(sb.count_o), 64'd0);
      chk("rd_empty", 64'(sb.empty_o), 64'd1);
      tick();
      rstn = 1'b1;
      tick();

      // Commit and flush in the same cycle
      alloc(32'h10, 32'hA, 4'hF);
      #1;
      chk("cf_idx_a", 64'(sb.alloc_idx_o), 64'd0);
      tick();
      alloc(32'h14, 32'hB, 4'hF);
      #1;
      chk("cf_idx_b", 64'(sb.alloc_idx_o), 64'd1);
      tick();
      alloc(32'h18, 32'hC, 4'hF);
      #1;
      chk("cf_idx_c", 64'(sb.alloc_idx_o), 64'd2);
      tick();
      idle();
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = 2'd0;
      tick();
      idle();
      alloc(32'h1C, 32'hD, 4'hF);
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = 2'd1;
      sb.flush_i        = 1'b1;
      #1;
      chk("cf_ready_flush", 64'(sb.alloc_ready_o), 64'd0);
      chk("cf_memv_a", 64'(sb.mem_req_valid_o), 64'd1);
      tick();
      idle();
      #1;
      chk("cf_count", 64'(sb.count_o), 64'd2);
      chk("cf_next_idx", 64'(sb.alloc_idx_o), 64'd2);
      sb.mem_req_ready_i = 1'b1;
      chk("cf_drain_a", 64'(sb.mem_req_addr_o), 64'h10);
      chk("cf_drain_a_data", 64'(sb.mem_req_data_o), 64'hA);
      tick();
      chk("cf_memv_b", 64'(sb.mem_req_valid_o), 64'd1);
      chk("cf_drain_b", 64'(sb.mem_req_addr_o), 64'h14);
      chk("cf_drain_b_data", 64'(sb.mem_req_data_o), 64'hB);
      tick();
      idle();
      #1;
      chk("cf_c_dropped", 64'(sb.mem_req_valid_o), 64'd0);
      chk("cf_count_end", 64'(sb.count_o), 64'd0);
      tick();

      // Forwarding / conservative stall
      alloc(32'h20, 32'h11111111, 4'hF);
      tick();
      alloc(32'h20, 32'h22222222, 4'hF);
      probe("fw_first", 32'h20, 4'hF, FWD, FWD ? 32'h11111111 : 32'h0, !FWD);
      tick();
      idle();
      probe("fw_young", 32'h23, 4'hF, FWD, FWD ? 32'h22222222 : 32'h0, !FWD);
      probe("fw_miss", 32'h24, 4'hF, 1'b0, 32'h0, 1'b0);
      sb.flush_i = 1'b1;
      tick();
      idle();
      alloc(32'h30, 32'h000000AB, 4'h1);
      probe("fw_not_yet", 32'h30, 4'hF, 1'b0, 32'h0, 1'b0);
      tick();
      idle();
      probe("fw_partial", 32'h30, 4'hF, 1'b0, 32'h0, 1'b1);
      probe("fw_byte", 32'h30, 4'h1, FWD, FWD ? 32'h000000AB : 32'h0, !FWD);
      probe("fw_disjoint", 32'h30, 4'h2, 1'b0, 32'h0, 1'b0);
      sb.flush_i = 1'b1;
      tick();
      idle();
      #1;
      chk("fw_flushed", 64'(sb.count_o), 64'd0);

      // Pipelined alloc/commit/drain across pointer wrap
      drained = 0;
      for (int k = 0; k < 14; k++) begin
         idle();
         sb.mem_req_ready_i = 1'b1;
         if (k < 10) begin
            alloc(32'h200 + 32'(4 * k), 32'hA5000000 | 32'(k), 4'hF);
         end
         if (k >= 1 && k <= 10) begin
            sb.commit_valid_i = 1'b1;
            sb.commit_idx_i   = 2'((2 + k - 1) % 4);
         end
         #1;
         if (k < 10) begin
            chk($sformatf("wr%0d_idx", k), 64'(sb.alloc_idx_o), 64'((2 + k) % 4));
         end
         if (sb.mem_req_valid_o) begin
            chk($sformatf("wr%0d_addr", k), 64'(sb.mem_req_addr_o), 64'(32'h200 + 4 * drained));
            chk($sformatf("wr%0d_data", k), 64'(sb.mem_req_data_o),
                64'(32'hA5000000 | 32'(drained)));
            drained++;
         end
         tick();
      end
      idle();
      #1;
      chk("wr_drained", 64'(drained), 64'd10);
      chk("wr_empty", 64'(sb.empty_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
